// File: rtl/gemm_pkg.sv
// Shared types, default widths and small helpers for the multi-lane GEMM engine.
package gemm_pkg;

  localparam int DefInDataWidth   = 8;
  localparam int DefOutDataWidth  = 32;
  localparam int DefNumLanes      = 4;
  localparam int DefAddrWidth     = 12;
  localparam int DefSizeAddrWidth = 8;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE,
    DRAIN,
    WRITE,
    DONE
  } gemm_state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

  // Lane `lane` of column tile `tile` holds a real column only while it is below the column count.
  function automatic logic lane_mask(input int unsigned tile, input int unsigned lane,
                                     input int unsigned lanes, input int unsigned cols);
    return (tile * lanes + lane) < cols;
  endfunction

endpackage

// File: rtl/gemm_mac_lane.sv
// One multiply-accumulate lane: extends both operands by mode, then loads or adds the product.
module gemm_mac_lane import gemm_pkg::*; #(
  parameter int InDataWidth  = DefInDataWidth,
  parameter int OutDataWidth = DefOutDataWidth
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid,
  input  logic                    first,
  input  logic                    signed_mode,
  input  logic [InDataWidth-1:0]  a,
  input  logic [InDataWidth-1:0]  b,
  output logic [OutDataWidth-1:0] acc
);

  localparam int ExtWidth = OutDataWidth - InDataWidth;

  logic [OutDataWidth-1:0] a_ext;
  logic [OutDataWidth-1:0] b_ext;
  logic [OutDataWidth-1:0] product;

  always_comb begin
    a_ext   = signed_mode ? {{ExtWidth{a[InDataWidth-1]}}, a} : {{ExtWidth{1'b0}}, a};
    b_ext   = signed_mode ? {{ExtWidth{b[InDataWidth-1]}}, b} : {{ExtWidth{1'b0}}, b};
    product = a_ext * b_ext;
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (valid) begin
      acc <= first ? product : acc + product;
    end
  end

endmodule

// File: rtl/gemm_multi_lane_top.sv
// GEMM engine: walks C row tiles, streams A scalars and packed B words, writes packed C words.
module gemm_multi_lane_top import gemm_pkg::*; #(
  parameter int InDataWidth   = DefInDataWidth,
  parameter int OutDataWidth  = DefOutDataWidth,
  parameter int NumLanes      = DefNumLanes,
  parameter int AddrWidth     = DefAddrWidth,
  parameter int SizeAddrWidth = DefSizeAddrWidth
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             start_i,
  input  logic                             signed_mode_i,
  input  logic [SizeAddrWidth-1:0]         M_size_i,
  input  logic [SizeAddrWidth-1:0]         K_size_i,
  input  logic [SizeAddrWidth-1:0]         N_size_i,
  output logic [AddrWidth-1:0]             sram_a_addr_o,
  input  logic [InDataWidth-1:0]           sram_a_rdata_i,
  output logic [AddrWidth-1:0]             sram_b_addr_o,
  input  logic [NumLanes*InDataWidth-1:0]  sram_b_rdata_i,
  output logic [AddrWidth-1:0]             sram_c_addr_o,
  output logic [NumLanes*OutDataWidth-1:0] sram_c_wdata_o,
  output logic                             sram_c_we_o,
  output logic [NumLanes-1:0]              sram_c_lane_en_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam logic [SizeAddrWidth-1:0] SizeOne = SizeAddrWidth'(1);

  gemm_state_e state_q, state_d;

  logic [SizeAddrWidth-1:0]         m_size_q, k_size_q, n_size_q, nt_q;
  logic [SizeAddrWidth-1:0]         m_q, t_q, k_q;
  logic                             signed_q, valid_q, first_q;
  logic                             zero_size, k_last, t_last, m_last;
  logic [NumLanes*OutDataWidth-1:0] acc_word;
  logic [NumLanes-1:0]              tile_mask;

  assign zero_size = (M_size_i == '0) || (K_size_i == '0) || (N_size_i == '0);
  assign k_last    = (k_q == k_size_q - SizeOne);
  assign t_last    = (t_q == nt_q - SizeOne);
  assign m_last    = (m_q == m_size_q - SizeOne);

  // NOTE: every variable gets its default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = zero_size ? DONE : COMPUTE;
      COMPUTE: if (k_last) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = (t_last && m_last) ? DONE : COMPUTE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_size_q <= '0;
      k_size_q <= '0;
      n_size_q <= '0;
      nt_q     <= '0;
      signed_q <= 1'b0;
      m_q      <= '0;
      t_q      <= '0;
      k_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          m_size_q <= M_size_i;
          k_size_q <= K_size_i;
          n_size_q <= N_size_i;
          nt_q     <= SizeAddrWidth'(ceil_div(32'(N_size_i), NumLanes));
          signed_q <= signed_mode_i;
          m_q      <= '0;
          t_q      <= '0;
          k_q      <= '0;
        end
        COMPUTE: k_q <= k_last ? '0 : k_q + SizeOne;
        WRITE: begin
          if (t_last) begin
            t_q <= '0;
            m_q <= m_q + SizeOne;
          end else begin
            t_q <= t_q + SizeOne;
          end
        end
        default: ;
      endcase
    end
  end

  // SRAM data returns one cycle after its address, so valid/first trail the COMPUTE cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      first_q <= 1'b0;
    end else begin
      valid_q <= (state_q == COMPUTE);
      first_q <= (state_q == COMPUTE) && (k_q == '0);
    end
  end

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    gemm_mac_lane #(
      .InDataWidth (InDataWidth),
      .OutDataWidth(OutDataWidth)
    ) u_lane (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .valid      (valid_q),
      .first      (first_q),
      .signed_mode(signed_q),
      .a          (sram_a_rdata_i),
      .b          (sram_b_rdata_i[l*InDataWidth +: InDataWidth]),
      .acc        (acc_word[l*OutDataWidth +: OutDataWidth])
    );
    assign tile_mask[l] = lane_mask(32'(t_q), l, NumLanes, 32'(n_size_q));
  end

  always_comb begin
    sram_a_addr_o    = '0;
    sram_b_addr_o    = '0;
    sram_c_addr_o    = '0;
    sram_c_wdata_o   = '0;
    sram_c_we_o      = 1'b0;
    sram_c_lane_en_o = '0;
    if (state_q == COMPUTE) begin
      sram_a_addr_o = AddrWidth'(m_q) * AddrWidth'(k_size_q) + AddrWidth'(k_q);
      sram_b_addr_o = AddrWidth'(k_q) * AddrWidth'(nt_q) + AddrWidth'(t_q);
    end
    if (state_q == WRITE) begin
      sram_c_addr_o    = AddrWidth'(m_q) * AddrWidth'(nt_q) + AddrWidth'(t_q);
      sram_c_wdata_o   = acc_word;
      sram_c_we_o      = 1'b1;
      sram_c_lane_en_o = tile_mask;
    end
  end

  assign busy_o = (state_q == COMPUTE) || (state_q == DRAIN) || (state_q == WRITE);
  assign done_o = (state_q == DONE);

endmodule
